// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches 32-bit words from instruction
// memory over req/ack, and hands each word plus its PC to decode over
// valid/ready. Handles redirects (including one that lands while a request is
// in flight), memory timeouts and misaligned redirect targets.
`timescale 1ns/1ps

module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [31:0] instr_pc_plus4,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        fault,
    output logic        fault_cause
);

    typedef enum logic [1:0] {BOOT, FETCH, HOLD, FAULT} state_t;

    // Last wait-counter value before a timeout is declared.
    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        kill_q, kill_d;      // in-flight request must be discarded
    logic [31:0] tgt_q, tgt_d;        // where to fetch once the killed ack returns
    logic [15:0] wait_q, wait_d;
    logic        fault_q, fault_d;
    logic        cause_q, cause_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] ipc_q, ipc_d;

    logic redir_ok;
    logic redir_bad;

    assign redir_ok  = redirect_valid && (redirect_pc[1:0] == 2'b00);
    assign redir_bad = redirect_valid && (redirect_pc[1:0] != 2'b00);

    // Outputs are decoded from registered state only.
    assign imem_req       = (state_q == FETCH);
    assign imem_addr      = pc_q;
    assign instr_valid    = (state_q == HOLD);
    assign instr          = instr_q;
    assign instr_pc       = ipc_q;
    assign instr_pc_plus4 = ipc_q + 32'd4;
    assign fault          = fault_q;
    assign fault_cause    = cause_q;

    // Next-state logic; a misaligned redirect overrides everything else.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        kill_d  = kill_q;
        tgt_d   = tgt_q;
        wait_d  = wait_q;
        fault_d = fault_q;
        cause_d = cause_q;
        instr_d = instr_q;
        ipc_d   = ipc_q;

        case (state_q)
            BOOT: begin
                if (redir_ok) pc_d = redirect_pc;
                state_d = FETCH;
                wait_d  = '0;
            end
            FETCH: begin
                if (imem_ack) begin
                    wait_d = '0;
                    if (kill_q || redir_ok) begin
                        // Stale word: drop it and re-issue at the newest target.
                        pc_d   = redir_ok ? redirect_pc : tgt_q;
                        kill_d = 1'b0;
                    end else begin
                        instr_d = imem_rdata;
                        ipc_d   = pc_q;
                        state_d = HOLD;
                    end
                end else begin
                    // Address stays put until the ack; remember the redirect.
                    if (redir_ok) begin
                        kill_d = 1'b1;
                        tgt_d  = redirect_pc;
                    end
                    if (wait_q == WAIT_LAST) begin
                        state_d = FAULT;
                        fault_d = 1'b1;
                        cause_d = 1'b0;
                        kill_d  = 1'b0;
                        wait_d  = '0;
                    end else begin
                        wait_d = wait_q + 16'd1;
                    end
                end
            end
            HOLD: begin
                // A redirect wins over the sequential pc+4, even on a handshake.
                if (redir_ok) begin
                    pc_d    = redirect_pc;
                    state_d = FETCH;
                    wait_d  = '0;
                end else if (instr_ready) begin
                    pc_d    = pc_q + 32'd4;
                    state_d = FETCH;
                    wait_d  = '0;
                end
            end
            FAULT: begin
                if (redir_ok) begin
                    pc_d    = redirect_pc;
                    state_d = FETCH;
                    fault_d = 1'b0;
                    cause_d = 1'b0;
                    wait_d  = '0;
                end
            end
            default: state_d = BOOT;
        endcase

        if (redir_bad) begin
            state_d = FAULT;
            fault_d = 1'b1;
            cause_d = 1'b1;
            kill_d  = 1'b0;
            wait_d  = '0;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            kill_q  <= 1'b0;
            tgt_q   <= '0;
            wait_q  <= '0;
            fault_q <= 1'b0;
            cause_q <= 1'b0;
            instr_q <= '0;
            ipc_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            kill_q  <= kill_d;
            tgt_q   <= tgt_d;
            wait_q  <= wait_d;
            fault_q <= fault_d;
            cause_q <= cause_d;
            instr_q <= instr_d;
            ipc_q   <= ipc_d;
        end
    end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Program-counter and instruction-fetch stage directly upstream of the instruction field decoder. Holds the PC, requests 32-bit words from instruction memory over a req/ack handshake, and presents each fetched word with its PC to decode through a valid/ready handshake. Supports redirects from branch/jump resolution, including a redirect that arrives while a memory request is in flight. Also detects memory timeouts and misaligned targets.

## Interface
- RESET_PC, 32'h0000_0000, PC of the first fetch after reset; must be word-aligned
- TIMEOUT, 255, max cycles a request may wait for imem_ack before fault; 1..65535
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- imem_req  out  1  memory request; high only in state FETCH
- imem_addr  out  32  byte address of request (= pc), bits [1:0] always 0
- imem_ack  in  1  memory returns imem_rdata this cycle; ignored unless imem_req=1
- imem_rdata  in  32  instruction word
- instr_valid  out  1  instr/instr_pc valid for decode
- instr_ready  in  1  decode accepts instr this cycle
- instr  out  32  fetched instruction word
- instr_pc  out  32  PC of instr
- instr_pc_plus4  out  32  instr_pc + 4, mod 2^32
- redirect_valid  in  1  single-cycle pulse: next fetch from redirect_pc
- redirect_pc  in  32  redirect target
- fault  out  1  sticky: timeout or misaligned redirect
- fault_cause  out  1  0 = timeout, 1 = misaligned; valid while fault=1

## Operation
- States: BOOT, FETCH, HOLD, FAULT.
- BOOT: reset state; no request; always -> FETCH next cycle.
- FETCH: imem_req=1, imem_addr=pc; addr held stable until ack or abort. Wait counter increments each FETCH cycle without ack.
  - ack, no kill pending: instr<=imem_rdata, instr_pc<=pc; -> HOLD.
  - ack, kill pending: data discarded; pc<=saved target, kill cleared; stay FETCH. Request re-issues next cycle with new address.
  - no ack, counter reaches TIMEOUT-1: -> FAULT, fault_cause=0. Request abandoned.
- HOLD: instr_valid=1. instr_ready=1 -> pc<=pc+4; -> FETCH.
- FAULT: no request, instr_valid=0. Exit only by reset or an aligned redirect, which -> FETCH at redirect_pc and clears fault.
- Redirect, redirect_pc[1:0]==0:
  - FETCH before ack: set kill, save target. If ack occurs in the same cycle, the ack is discarded.
  - HOLD: pc<=redirect_pc; -> FETCH; instr_valid drops next cycle. If instr_ready is also high that cycle, the instruction counts as consumed, but the next PC is still redirect_pc, not pc+4.
  - BOOT: pc<=redirect_pc.
- Redirect, redirect_pc[1:0]!=0: -> FAULT from any state, fault_cause=1, instr_valid=0, outstanding kill discarded.
  - A request in flight is abandoned. The memory side tolerates this, as with timeout.
- Wait counter clears on every state entry and on every ack.
- PC arithmetic is 32-bit wrap: 32'hFFFF_FFFC + 4 = 0.

## Timing
- Reset (async): state=BOOT, pc=RESET_PC, kill=0, counter=0, fault=0, fault_cause=0, instr=0, instr_pc=0.
  - Outputs during reset: imem_req=0, instr_valid=0; instr_pc_plus4=4.
- First imem_req: first rising edge after rst_n deasserts enters FETCH; req is high during the following cycle.
- imem_req and instr_valid are decoded from registered state, with no combinational path from inputs.
- Ack may arrive in the same cycle req rises. Zero-wait memory with ready decode gives 1 instruction per 2 cycles.
- Ack to instr_valid: 1 cycle. instr, instr_pc and instr_valid are stable while instr_valid=1 and instr_ready=0.
- Redirect to first request at the new target:
  - 1 cycle from HOLD or BOOT.
  - From FETCH: 1 cycle after the discarded ack.
- Timeout: fault rises after exactly TIMEOUT consecutive unacked FETCH cycles.

## Test plan
- Reset then zero-wait memory returning 32'h00042403 @0 and 32'h00060613 @4, decode always ready -> imem_addr 0 then 4. Each word appears on instr with matching instr_pc. First instr_valid in the 2nd cycle after reset release.
- Decode holds instr_ready=0 for 5 cycles in HOLD -> instr/instr_pc unchanged, no new imem_req, pc advances only after the ready cycle.
- Memory with 3-cycle ack latency; redirect_pc=32'h100 pulsed in cycle 1 of the wait -> returned word is never valid; next imem_addr=32'h100 with addr stable throughout the wait.
- Redirect 32'h40 in the same cycle as an instr_valid&&instr_ready handshake -> next imem_addr=32'h40, not pc+4.
- TIMEOUT=4, memory never acks -> fault=1 and fault_cause=0 after 4 FETCH cycles, imem_req=0. Then redirect_pc=8 -> fault clears, imem_addr=8.
- redirect_pc=32'h102 -> fault=1, fault_cause=1, instr_valid=0. Also pc at 32'hFFFF_FFFC consumed -> next imem_addr=0.
